ex_mul_sequencer: RTL and testbench

//  Multi-cycle shift-add multiply sequencer for the EX stage; replaces the single-cycle

---
 rtl/ex_ctrl_pkg.sv | 23 ++
 rtl/fa_nbit.sv | 13 +
 rtl/mul_step_adder.sv | 35 +++
 rtl/ex_mul_sequencer.sv | 117 +++++++++++
 tb/tb_ex_mul_sequencer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_ctrl_pkg.sv
// Shared EX-stage sequencer definitions: FSM state encoding, default sizes and
// the STEP/WIDTH legality check (also used by the divide sequencer).
package ex_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } ex_state_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_STEP  = 2;

  localparam int STEP_LEGAL_A = 1;
  localparam int STEP_LEGAL_B = 2;
  localparam int STEP_LEGAL_C = 4;

  function automatic bit step_legal(input int width, input int step);
    return ((step == STEP_LEGAL_A) || (step == STEP_LEGAL_B) || (step == STEP_LEGAL_C))
           && (width >= step) && ((width % step) == 0);
  endfunction

endpackage

// File: rtl/fa_nbit.sv
// N-bit adder used to sum partial products; carry out of the MSB is discarded
// because products are taken modulo 2^N.
module fa_nbit #(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/mul_step_adder.sv
// Combinational acc + mcand * digit, with the STEP partial products chained
// through fa_nbit adders. digit_i[STEP-1] is the most significant digit bit.
module mul_step_adder #(
  parameter int WIDTH = 32,
  parameter int STEP  = 2
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [STEP-1:0]  digit_i,
  output logic [WIDTH-1:0] sum_o
);

  for (genvar gi = 0; gi < STEP; gi++) begin : g_pp
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] pp;
    logic [WIDTH-1:0] sum;

    if (gi == 0) begin : g_first
      assign addend = acc_i;
    end else begin : g_next
      assign addend = g_pp[gi-1].sum;
    end

    assign pp = digit_i[gi] ? (mcand_i << gi) : '0;

    fa_nbit #(.N(WIDTH)) u_fa (
      .a_i   (addend),
      .b_i   (pp),
      .sum_o (sum)
    );
  end

  assign sum_o = g_pp[STEP-1].sum;

endmodule

// File: rtl/ex_mul_sequencer.sv
// Multi-cycle shift-add multiply sequencer for EX: stalls the pipeline while retiring
// STEP multiplier bits per cycle. Define MUL_EARLY_OUT_EN to finish once the multiplier is exhausted.
module ex_mul_sequencer
  import ex_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEP  = DEF_STEP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             stall,
  output logic [WIDTH-1:0] result,
  output logic             result_valid
);

  localparam int NSTEP   = WIDTH / STEP;
  localparam int CW      = $clog2(NSTEP) + 1;
  localparam bit STEP_OK = step_legal(WIDTH, STEP);

  ex_state_e        state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] step_sum;
  logic [CW-1:0]    count_q, count_d;
  logic [STEP-1:0]  digit;

  // Vectors are LSB-at-0 here, so the least significant multiplier bits are [STEP-1:0].
  assign digit = mplier_q[STEP-1:0];

  mul_step_adder #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .digit_i (digit),
    .sum_o   (step_sum)
  );

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    count_d      = count_q;
    stall        = 1'b0;
    result_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // An illegal WIDTH/STEP pairing never issues.
        if (reset && start && !flush && STEP_OK) begin
          stall    = 1'b1;
          acc_d    = '0;
          mcand_d  = opA;
          mplier_d = opB;
          count_d  = CW'(NSTEP);
`ifdef MUL_EARLY_OUT_EN
          state_d  = (opB == '0) ? ST_DONE : ST_BUSY;
`else
          state_d  = ST_BUSY;
`endif
        end
      end
      ST_BUSY: begin
        stall = reset;
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d    = step_sum;
          mcand_d  = mcand_q << STEP;
          mplier_d = mplier_q >> STEP;
          count_d  = count_q - CW'(1);
          if (count_q == CW'(1)) begin
            state_d = ST_DONE;
          end
`ifdef MUL_EARLY_OUT_EN
          if (mplier_d == '0) begin
            state_d = ST_DONE;
          end
`endif
        end
      end
      ST_DONE: begin
        result_valid = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      // Capture the final product on entry to DONE; held until the next product.
      if (state_d == ST_DONE) begin
        result_q <= acc_d;
      end
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_ex_mul_sequencer.sv
// Randomised and directed bench for ex_mul_sequencer against a cycle-count/product model.
module tb_ex_mul_sequencer;

  localparam int W     = 32;
  localparam int STEP  = 2;
  localparam int NSTEP = W / STEP;

`ifdef MUL_EARLY_OUT_EN
  localparam int L76 = 3, LFULL = 17, L35 = 3, L44 = 3, L23 = 2, L93 = 2, L0 = 1;
`else
  localparam int L76 = 17, LFULL = 17, L35 = 17, L44 = 17, L23 = 17, L93 = 17, L0 = 17;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] opA = '0;
  logic [W-1:0] opB = '0;
  logic         stall;
  logic [W-1:0] result;
  logic         result_valid;

  int n_cmp = 0;
  int n_bad = 0;

  ex_mul_sequencer #(.WIDTH(W), .STEP(STEP)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .flush        (flush),
    .opA          (opA),
    .opB          (opB),
    .stall        (stall),
    .result       (result),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  // Model: an operation is "in flight" for a number of steps, then shows one valid cycle.
  bit           m_busy = 1'b0;
  bit           m_done = 1'b0;
  int           m_left = 0;
  logic [W-1:0] m_prod = '0;
  logic [W-1:0] m_res  = '0;

  function automatic int steps_for(input logic [W-1:0] b);
`ifdef MUL_EARLY_OUT_EN
    int nbits = 0;
    for (int i = 0; i < W; i++) if (b[i]) nbits = i + 1;
    return (nbits + STEP - 1) / STEP;
`else
    return NSTEP;
`endif
  endfunction

  task automatic model_update();
    logic [63:0] p;
    if (m_done) begin
      m_done = 1'b0;
    end else if (m_busy) begin
      if (flush) begin
        m_busy = 1'b0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_res  = m_prod;
        end
      end
    end else if (start && !flush) begin
      p      = {32'b0, opA} * {32'b0, opB};
      m_prod = p[W-1:0];
      m_left = steps_for(opB);
      if (m_left == 0) begin
        m_done = 1'b1;
        m_res  = m_prod;
      end else begin
        m_busy = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_done = 1'b0;
    m_left = 0;
    m_res  = '0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    chk("stall", {63'b0, stall},
        {63'b0, reset & (m_busy | (!m_busy & !m_done & start & !flush))});
    chk("result_valid", {63'b0, result_valid}, {63'b0, m_done});
    chk("result", {32'b0, result}, {32'b0, m_res});
  end

  task automatic step();
    @(posedge clk);
    if (reset) model_update();
    #1;
  endtask

  task automatic run_seq(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                         input int ncyc, output int p1, output int p2, output int npulse,
                         output int nstall, output logic [W-1:0] r1);
    p1 = -1; p2 = -1; npulse = 0; nstall = 0; r1 = '0;
    opA = a; opB = b; start = (hold > 0);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (stall) nstall++;
      if (result_valid) begin
        npulse++;
        if (p1 < 0) begin
          p1 = c;
          r1 = result;
        end else if (p2 < 0) begin
          p2 = c;
        end
      end
      step();
      start = (c + 1 < hold);
    end
    $display("run %0h*%0h hold=%0d: pulses=%0d first@%0d second@%0d result=%0h stall_cycles=%0d",
             a, b, hold, npulse, p1, p2, r1, nstall);
  endtask

  initial begin
    int p1, p2, np, ns;
    logic [W-1:0] r;

    #1;
    chk("reset_stall", {63'b0, stall}, 64'd0);
    chk("reset_valid", {63'b0, result_valid}, 64'd0);
    chk("reset_result", {32'b0, result}, 64'd0);
    step();
    step();
    reset = 1'b1;
    step();

    // 7*6
    run_seq(32'd7, 32'd6, 1, 20, p1, p2, np, ns, r);
    chk("t1_lat", p1, L76);
    chk("t1_result", r, 42);
    chk("t1_pulses", np, 1);
    chk("t1_stall_cycles", ns, L76);

    // Wrap-around products
    run_seq(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 20, p1, p2, np, ns, r);
    chk("t2_lat", p1, LFULL);
    chk("t2_result_ff", r, 1);
    run_seq(32'h8000_0000, 32'd2, 1, 20, p1, p2, np, ns, r);
    chk("t2_result_ovf", r, 0);
    chk("t2_pulses", np, 1);

    // Flush in BUSY cycle 5, new 3*5 issued in cycle 7
    opA = 32'h1234; opB = 32'hFFFF_FFFF; start = 1'b1; np = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 5) chk("t3_stall_flush_cycle", {63'b0, stall}, 64'd1);
      if (c == 6) chk("t3_stall_after_flush", {63'b0, stall}, 64'd0);
      if (result_valid) np++;
      step();
      start = 1'b0;
      flush = (c + 1 == 5);
    end
    chk("t3_no_pulse", np, 0);
    run_seq(32'd3, 32'd5, 1, 20, p1, p2, np, ns, r);
    chk("t3_lat_abs", p1 + 7, 7 + L35);
    chk("t3_result", r, 15);

    // Async reset in BUSY cycle 9
    opA = 32'h55; opB = 32'hFFFF_FFFF; start = 1'b1;
    for (int c = 0; c < 9; c++) begin
      step();
      start = 1'b0;
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("t4_stall", {63'b0, stall}, 64'd0);
    chk("t4_valid", {63'b0, result_valid}, 64'd0);
    chk("t4_result", {32'b0, result}, 64'd0);
    start = 1'b1; opA = 32'd4; opB = 32'd4;
    #1;
    chk("t4_stall_start_in_reset", {63'b0, stall}, 64'd0);
    step();
    reset = 1'b1;
    run_seq(32'd4, 32'd4, 1, 20, p1, p2, np, ns, r);
    chk("t4_lat", p1, L44);
    chk("t4_result_after", r, 16);

    // start held through DONE: single pulse, then back-to-back issue
    run_seq(32'd2, 32'd3, L23 + 1, L23 + 6, p1, p2, np, ns, r);
    chk("t5_lat", p1, L23);
    chk("t5_pulses", np, 1);
    chk("t5_stall_cycles", ns, L23);
    chk("t5_result", r, 6);
    run_seq(32'd2, 32'd3, L23 + 2, 2 * L23 + 4, p1, p2, np, ns, r);
    chk("t5b_first", p1, L23);
    chk("t5b_second", p2, 2 * L23 + 1);
    chk("t5b_pulses", np, 2);

    // Operand-dependent latency cases
    run_seq(32'd9, 32'd3, 1, 20, p1, p2, np, ns, r);
    chk("t6_lat", p1, L93);
    chk("t6_result", r, 27);
    run_seq(32'd5, 32'd0, 1, 20, p1, p2, np, ns, r);
    chk("t6_zero_lat", p1, L0);
    chk("t6_zero_result", r, 0);
    chk("t6_zero_stall", ns, L0);

    // Random traffic, checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 24) == 0);
      opA   = $urandom;
      case ($urandom_range(0, 3))
        0:       opB = '0;
        1:       opB = W'($urandom_range(0, 255));
        default: opB = $urandom;
      endcase
      step();
    end
    start = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 20; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
